mirfak_lsu: RTL and testbench

MIRFAK_LSU -- requirements
Module: mirfak_lsu

---
 rtl/mirfak_lsu_pkg.sv | 26 ++
 rtl/mirfak_lsu_align.sv | 64 ++++++
 rtl/mirfak_lsu.sv | 179 +++++++++++++++++
 tb/tb_mirfak_lsu.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mirfak_lsu_pkg.sv
// Shared mirfak LSU definitions: data-type encodings, FSM states, alignment helper.
// The optional bus-error feature is selected in mirfak_lsu.sv by MIRFAK_LSU_BUSERR_EN.
package mirfak_lsu_pkg;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUS  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  // Type 2'b11 is handled like a word access.
  function automatic logic lsu_aligned(input logic [1:0] dtype, input logic [1:0] off);
    logic ok;
    case (dtype)
      LSU_BYTE: ok = 1'b1;
      LSU_HALF: ok = ~off[0];
      default:  ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mirfak_lsu_align.sv
// Byte-lane steering: store select/data replication and load extraction with extension.
module mirfak_lsu_align
  import mirfak_lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_sel,
  output logic [31:0] st_dat,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_type,
  input  logic        ld_sext,
  input  logic [31:0] ld_bus_dat,
  output logic [31:0] ld_rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lane select and replicated write data
  always_comb begin
    st_sel = 4'b1111;
    st_dat = st_wdata;
    case (st_type)
      LSU_BYTE: begin
        st_sel = 4'b0001 << st_off;
        st_dat = {4{st_wdata[7:0]}};
      end
      LSU_HALF: begin
        st_sel = 4'b0011 << {st_off[1], 1'b0};
        st_dat = {2{st_wdata[15:0]}};
      end
      default: begin
        st_sel = 4'b1111;
        st_dat = st_wdata;
      end
    endcase
  end

  // Load lane extraction followed by sign/zero extension
  always_comb begin
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    ld_rdata = ld_bus_dat;
    case (ld_off)
      2'b00:   byte_s = ld_bus_dat[7:0];
      2'b01:   byte_s = ld_bus_dat[15:8];
      2'b10:   byte_s = ld_bus_dat[23:16];
      2'b11:   byte_s = ld_bus_dat[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ld_off[1]) begin
      half_s = ld_bus_dat[31:16];
    end else begin
      half_s = ld_bus_dat[15:0];
    end
    case (ld_type)
      LSU_BYTE: ld_rdata = {{24{ld_sext & byte_s[7]}}, byte_s};
      LSU_HALF: ld_rdata = {{16{ld_sext & half_s[15]}}, half_s};
      default:  ld_rdata = ld_bus_dat;
    endcase
  end

endmodule

// File: rtl/mirfak_lsu.sv
// Load/store unit: one Wishbone B4 classic access per WB-stage memory instruction.
// Define MIRFAK_LSU_BUSERR_EN to let dwbm_err_i terminate a cycle and raise ld/st faults.
module mirfak_lsu
  import mirfak_lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_address_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [1:0]  lsu_data_type_i,
  input  logic        lsu_sign_ext_i,
  input  logic        lsu_mem_read_i,
  input  logic        lsu_mem_write_i,
  input  logic        lsu_kill_i,
  input  logic        lsu_advance_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_busy_o,
  output logic        lsu_ld_misaligned_o,
  output logic        lsu_st_misaligned_o,
  output logic        lsu_ld_fault_o,
  output logic        lsu_st_fault_o,
  output logic [31:0] dwbm_addr_o,
  output logic [31:0] dwbm_dat_o,
  output logic [3:0]  dwbm_sel_o,
  output logic        dwbm_cyc_o,
  output logic        dwbm_stb_o,
  output logic        dwbm_we_o,
  input  logic [31:0] dwbm_dat_i,
  input  logic        dwbm_ack_i,
  input  logic        dwbm_err_i
);

  lsu_state_e  state_r, state_nxt_s;
  logic        req_s, aligned_s, valid_s, err_s, term_s, kill_any_s;
  logic [3:0]  sel_s, sel_r;
  logic [31:0] dat_s, ext_s, dat_r, addr_r, rdata_r;
  logic        cyc_r, stb_r, we_r, sext_r, kill_pend_r, ld_fault_r, st_fault_r;
  logic [1:0]  off_r, type_r;

  assign req_s      = (lsu_mem_read_i | lsu_mem_write_i) & ~lsu_kill_i;
  assign aligned_s  = lsu_aligned(lsu_data_type_i, lsu_address_i[1:0]);
  assign valid_s    = req_s & aligned_s;
  assign kill_any_s = kill_pend_r | lsu_kill_i;

`ifdef MIRFAK_LSU_BUSERR_EN
  assign err_s = dwbm_err_i;
`else
  // Bus errors are masked; only ack can end a cycle.
  assign err_s = dwbm_err_i & 1'b0;
`endif
  assign term_s = dwbm_ack_i | err_s;

  assign lsu_ld_misaligned_o = req_s & ~aligned_s & ~lsu_mem_write_i;
  assign lsu_st_misaligned_o = req_s & ~aligned_s & lsu_mem_write_i;
  assign lsu_busy_o          = ((state_r == LSU_IDLE) & valid_s) | (state_r == LSU_BUS);

  assign lsu_rdata_o    = rdata_r;
  assign lsu_ld_fault_o = ld_fault_r;
  assign lsu_st_fault_o = st_fault_r;
  assign dwbm_addr_o    = addr_r;
  assign dwbm_dat_o     = dat_r;
  assign dwbm_sel_o     = sel_r;
  assign dwbm_cyc_o     = cyc_r;
  assign dwbm_stb_o     = stb_r;
  assign dwbm_we_o      = we_r;

  mirfak_lsu_align u_align (
    .st_off     (lsu_address_i[1:0]),
    .st_type    (lsu_data_type_i),
    .st_wdata   (lsu_wdata_i),
    .st_sel     (sel_s),
    .st_dat     (dat_s),
    .ld_off     (off_r),
    .ld_type    (type_r),
    .ld_sext    (sext_r),
    .ld_bus_dat (dwbm_dat_i),
    .ld_rdata   (ext_s)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= LSU_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      LSU_IDLE: begin
        if (valid_s) begin
          state_nxt_s = LSU_BUS;
        end else begin
          state_nxt_s = LSU_IDLE;
        end
      end
      LSU_BUS: begin
        if (term_s) begin
          state_nxt_s = kill_any_s ? LSU_IDLE : LSU_DONE;
        end else begin
          state_nxt_s = LSU_BUS;
        end
      end
      LSU_DONE: begin
        if (lsu_advance_i | lsu_kill_i) begin
          state_nxt_s = LSU_IDLE;
        end else begin
          state_nxt_s = LSU_DONE;
        end
      end
      default: state_nxt_s = LSU_IDLE;
    endcase
  end

  // Bus request registers, result capture and fault flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r      <= 32'h0000_0000;
      dat_r       <= 32'h0000_0000;
      sel_r       <= 4'b0000;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      off_r       <= 2'b00;
      type_r      <= 2'b00;
      sext_r      <= 1'b0;
      kill_pend_r <= 1'b0;
      rdata_r     <= 32'h0000_0000;
      ld_fault_r  <= 1'b0;
      st_fault_r  <= 1'b0;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (valid_s) begin
            addr_r      <= {lsu_address_i[31:2], 2'b00};
            dat_r       <= dat_s;
            sel_r       <= sel_s;
            we_r        <= lsu_mem_write_i;
            cyc_r       <= 1'b1;
            stb_r       <= 1'b1;
            off_r       <= lsu_address_i[1:0];
            type_r      <= lsu_data_type_i;
            sext_r      <= lsu_sign_ext_i;
            kill_pend_r <= 1'b0;
          end
        end
        LSU_BUS: begin
          // A kill seen at any point of the cycle discards its result.
          if (lsu_kill_i) begin
            kill_pend_r <= 1'b1;
          end
          if (term_s) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            if (!kill_any_s) begin
              rdata_r    <= (we_r | err_s) ? 32'h0000_0000 : ext_s;
              ld_fault_r <= err_s & ~we_r;
              st_fault_r <= err_s & we_r;
            end
          end
        end
        LSU_DONE: begin
          if (lsu_advance_i | lsu_kill_i) begin
            ld_fault_r <= 1'b0;
            st_fault_r <= 1'b0;
          end
        end
        default: begin
          cyc_r <= 1'b0;
          stb_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mirfak_lsu.sv
// Self-checking bench for mirfak_lsu: directed scenarios plus randomized accesses against a lane model.
module tb_mirfak_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata, rdata, wb_addr, wb_dat_o, wb_dat_i;
  logic [1:0]  dtype;
  logic        sext, rd, wr, kill, advance, busy, ld_mis, st_mis, ld_fault, st_fault;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  int          slv_lat = 0;
  int          slv_cnt = 0;
  logic        slv_err_mode = 1'b0;
  logic        slv_both = 1'b0;

`ifdef MIRFAK_LSU_BUSERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mirfak_lsu dut (
    .clk_i(clk), .rst_i(rst), .lsu_address_i(address), .lsu_wdata_i(wdata),
    .lsu_data_type_i(dtype), .lsu_sign_ext_i(sext), .lsu_mem_read_i(rd),
    .lsu_mem_write_i(wr), .lsu_kill_i(kill), .lsu_advance_i(advance),
    .lsu_rdata_o(rdata), .lsu_busy_o(busy), .lsu_ld_misaligned_o(ld_mis),
    .lsu_st_misaligned_o(st_mis), .lsu_ld_fault_o(ld_fault), .lsu_st_fault_o(st_fault),
    .dwbm_addr_o(wb_addr), .dwbm_dat_o(wb_dat_o), .dwbm_sel_o(wb_sel),
    .dwbm_cyc_o(wb_cyc), .dwbm_stb_o(wb_stb), .dwbm_we_o(wb_we),
    .dwbm_dat_i(wb_dat_i), .dwbm_ack_i(wb_ack), .dwbm_err_i(wb_err)
  );

  // Wishbone slave: responds slv_lat cycles after cyc rises; err-only mode acks two cycles after err.
  always_ff @(posedge clk) begin
    if (!wb_cyc) slv_cnt <= 0;
    else         slv_cnt <= slv_cnt + 1;
  end

  always_comb begin
    wb_ack = 1'b0;
    wb_err = 1'b0;
    if (wb_cyc && wb_stb) begin
      if (slv_both) begin
        wb_ack = (slv_cnt == slv_lat);
        wb_err = (slv_cnt == slv_lat);
      end else if (slv_err_mode) begin
        wb_err = (slv_cnt == slv_lat);
        wb_ack = (slv_cnt == slv_lat + 2);
      end else begin
        wb_ack = (slv_cnt == slv_lat);
      end
    end
  end

  function automatic bit m_aligned(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'd0) return 1'b1;
    if (t == 2'd1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] t, input logic s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (t == 2'd0) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (s && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (t == 2'd1) begin
      v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (s && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_sel(input logic [1:0] t, input logic [31:0] a);
    if (t == 2'd0) return 4'(1 << (a % 4));
    if (t == 2'd1) return 4'(3 << (2 * ((a / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_dat(input logic [1:0] t, input logic [31:0] w);
    if (t == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (t == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] w, input logic [1:0] t,
                         input logic s, input logic r, input logic wr_en, input int lat,
                         input logic [31:0] rdat, input logic errm, input logic bothm);
    bit          done, seen;
    int          nbusy, term;
    bit          fault;
    logic [3:0]  c_sel;
    logic [31:0] c_addr, c_dat;
    logic        c_we;
    slv_lat = lat; slv_err_mode = errm; slv_both = bothm; wb_dat_i = rdat;
    @(posedge clk); #1;
    address = a; wdata = w; dtype = t; sext = s; rd = r; wr = wr_en;
    if (!m_aligned(t, a)) begin
      @(negedge clk);
      checks++; if (ld_mis !== (r & ~wr_en)) begin errors++; $display("FAIL %s ld_misaligned: got %b expected %b", tag, ld_mis, r & ~wr_en); end
      checks++; if (st_mis !== wr_en) begin errors++; $display("FAIL %s st_misaligned: got %b expected %b", tag, st_mis, wr_en); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s misaligned busy: got %b expected 0", tag, busy); end
      @(negedge clk);
      checks++; if (wb_cyc !== 1'b0) begin errors++; $display("FAIL %s misaligned cyc: got %b expected 0", tag, wb_cyc); end
      #1; rd = 1'b0; wr = 1'b0;
      return;
    end
    term  = (!ERR_EN && errm && !bothm) ? lat + 2 : lat;
    fault = ERR_EN && (errm || bothm);
    done = 1'b0; seen = 1'b0; nbusy = 0;
    c_sel = 4'h0; c_addr = 32'h0; c_dat = 32'h0; c_we = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if ((ld_mis | st_mis) !== 1'b0) begin errors++; $display("FAIL %s aligned misaligned flag: got %b expected 0", tag, ld_mis | st_mis); end
      end
      if (wb_cyc) begin seen = 1'b1; c_sel = wb_sel; c_addr = wb_addr; c_dat = wb_dat_o; c_we = wb_we; end
      if (!busy) begin done = 1'b1; break; end
      nbusy++;
    end
    checks++; if (!done || !seen) begin errors++; $display("FAIL %s completion: done %b cyc_seen %b expected 1 1", tag, done, seen); end
    checks++; if (nbusy != term + 2) begin errors++; $display("FAIL %s busy cycles: got %0d expected %0d", tag, nbusy, term + 2); end
    checks++; if (c_sel !== m_sel(t, a)) begin errors++; $display("FAIL %s sel: got %b expected %b", tag, c_sel, m_sel(t, a)); end
    checks++; if (c_addr !== (a & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s addr: got %h expected %h", tag, c_addr, a & 32'hFFFF_FFFC); end
    checks++; if (c_we !== wr_en) begin errors++; $display("FAIL %s we: got %b expected %b", tag, c_we, wr_en); end
    if (wr_en) begin
      checks++; if (c_dat !== m_dat(t, w)) begin errors++; $display("FAIL %s dat_o: got %h expected %h", tag, c_dat, m_dat(t, w)); end
    end
    exp_rdata = (wr_en || fault) ? 32'h0 : m_load(t, s, a, rdat);
    for (int h = 0; h < 2; h++) begin
      checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s rdata: got %h expected %h", tag, rdata, exp_rdata); end
      checks++; if (ld_fault !== (fault & ~wr_en) || st_fault !== (fault & wr_en)) begin errors++; $display("FAIL %s faults: got %b%b expected %b%b", tag, ld_fault, st_fault, fault & ~wr_en, fault & wr_en); end
      checks++; if (wb_cyc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s done idle bus: cyc %b busy %b expected 0 0", tag, wb_cyc, busy); end
      @(negedge clk);
    end
    #1; advance = 1'b1; rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1; advance = 1'b0;
    @(negedge clk);
    checks++; if (ld_fault !== 1'b0 || st_fault !== 1'b0) begin errors++; $display("FAIL %s faults after advance: got %b%b expected 00", tag, ld_fault, st_fault); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL %s rdata after advance: got %h expected %h", tag, rdata, exp_rdata); end
  endtask

  task automatic test_reset();
    rst = 1'b1; address = 32'h0; wdata = 32'h0; dtype = 2'd0; sext = 1'b0;
    rd = 1'b0; wr = 1'b0; kill = 1'b0; advance = 1'b0; wb_dat_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 7'h0) begin errors++; $display("FAIL reset ctrl: got %b expected 0", {wb_cyc, wb_stb, wb_we, wb_sel}); end
    checks++; if ({wb_addr, wb_dat_o, rdata} !== 96'h0) begin errors++; $display("FAIL reset data: got %h %h %h expected 0", wb_addr, wb_dat_o, rdata); end
    checks++; if ({busy, ld_fault, st_fault} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b expected 000", {busy, ld_fault, st_fault}); end
    #1; rst = 1'b0;
  endtask

  task automatic test_directed();
    run_txn("ld_word",   32'h100, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    run_txn("ld_byte_s", 32'h103, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0, 0, 32'h80FFFFFF, 1'b0, 1'b0);
    checks++; if (exp_rdata !== 32'hFFFFFF80 || rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_s value: got %h expected FFFFFF80", rdata); end
    run_txn("ld_byte_u", 32'h103, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1, 32'h80FFFFFF, 1'b0, 1'b0);
    checks++; if (rdata !== 32'h00000080) begin errors++; $display("FAIL ld_byte_u value: got %h expected 00000080", rdata); end
    run_txn("st_half",   32'h202, 32'h1234ABCD, 2'd1, 1'b0, 1'b0, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    run_txn("ld_type11", 32'h108, 32'h0, 2'd3, 1'b1, 1'b1, 1'b0, 2, 32'h87654321, 1'b0, 1'b0);
  endtask

  task automatic test_misaligned();
    run_txn("mis_ld_word", 32'h101, 32'h0, 2'd2, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    run_txn("mis_st_half", 32'h203, 32'h55AA, 2'd1, 1'b0, 1'b1, 1'b1, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_bus_error();
    run_txn("st_err",   32'h240, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 1'b1, 1, 32'h0, 1'b1, 1'b0);
    run_txn("ld_both",  32'h244, 32'h0, 2'd1, 1'b1, 1'b1, 1'b0, 0, 32'h0000F123, 1'b0, 1'b1);
  endtask

  task automatic test_kill_reset();
    bit gone;
    slv_lat = 3; slv_err_mode = 1'b0; slv_both = 1'b0; wb_dat_i = 32'h13579BDF;
    @(posedge clk); #1;
    address = 32'h300; dtype = 2'd2; sext = 1'b0; rd = 1'b1; wr = 1'b0;
    @(posedge clk); #1; kill = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || wb_cyc !== 1'b1) begin errors++; $display("FAIL kill in bus: busy %b cyc %b expected 1 1", busy, wb_cyc); end
    gone = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!wb_cyc) begin gone = 1'b1; break; end
    end
    checks++; if (!gone) begin errors++; $display("FAIL kill completion: cyc still %b expected 0", wb_cyc); end
    checks++; if (busy !== 1'b0 || ld_fault !== 1'b0 || rdata !== exp_rdata) begin errors++; $display("FAIL kill discard: busy %b fault %b rdata %h expected 0 0 %h", busy, ld_fault, rdata, exp_rdata); end
    #1; kill = 1'b0; address = 32'h304; slv_lat = 5;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kill back to idle: busy %b expected 1", busy); end
    @(posedge clk); @(posedge clk); #1; rst = 1'b1; rd = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    exp_rdata = 32'h0;
    @(negedge clk);
    checks++; if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 7'h0 || {wb_addr, wb_dat_o} !== 64'h0) begin errors++; $display("FAIL mid reset bus: cyc %b sel %b addr %h expected 0", wb_cyc, wb_sel, wb_addr); end
    checks++; if ({busy, ld_fault, st_fault} !== 3'b000 || rdata !== 32'h0) begin errors++; $display("FAIL mid reset state: flags %b rdata %h expected 000 0", {busy, ld_fault, st_fault}, rdata); end
    repeat (8) @(negedge clk);
    checks++; if (wb_cyc !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL post reset quiet: cyc %b rdata %h expected 0 0", wb_cyc, rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  t;
    int          op;
    logic        em, bm;
    for (int i = 0; i < 40; i++) begin
      t = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (t == 2'd1) a[0] = 1'b0;
        if (t >= 2'd2) a[1:0] = 2'b00;
      end
      op = $urandom_range(0, 2);
      em = ($urandom_range(0, 5) == 0);
      bm = em ? 1'($urandom_range(0, 1)) : 1'b0;
      run_txn("random", a, $urandom, t, 1'($urandom_range(0, 1)), (op != 1), (op != 0),
              $urandom_range(0, 3), $urandom, em, bm);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_bus_error();
    test_kill_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
